mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage integer pipeline. It consumes the EX/MEM latch outputs (`ex_*`) and, for loads and stores, runs a transaction on the shared system bus as an initiator. It raises `busy` to stall the pipeline while the bus access is in flight, detects misaligned word accesses, and registers the stage result into the MEM/WB latch (`mem_*`). It also provides a same-cycle forwarding value to the decode stage.

## Interface
- No parameters. Widths come from the shared defines: WORD_ADDR 30, WORD_DATA 32, MEM_OP 2, CTRL_OP 2, REG_ADDR 5, ISA_EXP 3.
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `stall`, `flush`  in  1  pipeline control, from the controller
- `ex_pc`  in  30  word PC
- `ex_en_`  in  1  active-low valid
- `ex_br_flag`  in  1
- `ex_mem_op`  in  2  NOP=0, LDW=1, STW=2
- `ex_mem_wr_data`  in  32
- `ex_ctrl_op`  in  2
- `ex_dst_addr`  in  5
- `ex_gpr_we_`  in  1  active-low
- `ex_exp_code`  in  3
- `ex_out`  in  32  ALU result; this is the byte address for LDW/STW
- `bus_rd_data`  in  32  read data
- `bus_rdy_`  in  1  active-low ready
- `bus_grnt_`  in  1  active-low grant
- `bus_req_`  out  1  active-low request
- `bus_addr`  out  30  word address
- `bus_as_`  out  1  active-low address strobe
- `bus_rw`  out  1  READ=1, WRITE=0
- `bus_wr_data`  out  32
- `busy`  out  1  stall request to the controller
- `mem_fwd_data`  out  32  combinational stage result, forwarded to decode
- `mem_pc`, `mem_en_`, `mem_br_flag`, `mem_ctrl_op`, `mem_dst_addr`, `mem_gpr_we_`, `mem_exp_code`, `mem_out`  out  MEM/WB latch, widths as the `ex_*` inputs

## Operation
- **Access required** when all of the following hold: `ex_en_`=0, `ex_mem_op`≠NOP, `ex_out[1:0]`=0, and `flush`=0.
- **Misaligned** when `ex_en_`=0, `ex_mem_op`≠NOP and `ex_out[1:0]`≠0.
  - No bus request is issued.
  - Result is 0.
  - Exception code is MISS_ALIGN (3'h4).
- **Bus drive:**
  - `bus_addr`=`ex_out[31:2]`.
  - `bus_rw`=1 for LDW, 0 for STW.
  - `bus_wr_data`=`ex_mem_wr_data`.
- **Stage result** (also driven on `mem_fwd_data`):
  - LDW: `bus_rd_data` during the ACCESS cycle that sees `bus_rdy_`=0; the latched read data in WAIT.
  - STW and NOP: `ex_out`.
- **Bus FSM** states are IDLE, REQ, ACCESS, WAIT. Reset state is IDLE.
  - IDLE: if an access is required, set `busy`=1 and `bus_req_`=0, then go to REQ.
  - REQ: hold `bus_req_`=0 and `busy`=1. On `bus_grnt_`=0, drive `bus_as_`=0 with addr/rw/data and go to ACCESS.
  - ACCESS: hold `bus_req_`=0; addr/rw/data stay stable. While `bus_rdy_`=1, keep `busy`=1. On `bus_rdy_`=0:
    - set `busy`=0;
    - capture `bus_rd_data`;
    - release `bus_req_` in the next cycle;
    - next state is WAIT if `stall`=1, else IDLE.
  - WAIT: `busy`=0, result comes from the latched data, no new request. Go to IDLE when `stall`=0.
- An in-flight transaction always completes. `flush` only affects the latch update.
- **MEM/WB latch update priority:** reset, then `stall`, then `flush`, then misaligned, then normal.
  - `stall`: hold all values.
  - `flush`: bubble, i.e. `en_`=1, `gpr_we_`=1, `exp_code`=0, `ctrl_op`=0, `out`=0.
  - Misaligned: pass pc/en_/br_flag through, `gpr_we_`=1, `exp_code`=MISS_ALIGN, `out`=0.
  - Normal: pass all fields through, `out`=stage result.
- **Incoming exception:** if `ex_exp_code`≠0, the request is suppressed and the code passes through unchanged.

## Timing
- **Reset values:**
  - FSM state IDLE.
  - `bus_req_`=1, `bus_as_`=1, `bus_rw`=1, `bus_addr`=0, `bus_wr_data`=0.
  - `busy`=0.
  - All `mem_*` =0, except `mem_en_`=1 and `mem_gpr_we_`=1.
- Asserting `reset` mid-transaction returns the FSM to IDLE immediately and releases the bus asynchronously.
- `busy` is combinational from the state, `ex_*` and `bus_rdy_`. It rises in the same cycle the access instruction is presented.
- **Minimum latency** with a zero-wait slave and immediate grant: 3 cycles (IDLE→REQ→ACCESS with `rdy_`, latch on the third edge).
- `bus_as_` is asserted for exactly one cycle per transaction, the first cycle of ACCESS.
- Non-memory and misaligned instructions pass to the latch with 1 cycle latency and no busy cycles.

## Structure
- Shared package/defines:
  - MEM_OP encodings;
  - ISA_EXP codes (MISS_ALIGN=3'h4);
  - READ/WRITE;
  - active-low ENABLE_/DISABLE_ constants;
  - the bus FSM state encoding.
- One sub-module, `mem_reg`: the MEM/WB latch with its priority logic. The bus FSM, alignment check and result mux stay in `mem_stage`.

## Test plan
- **LDW to `ex_out`=0x100**, grant immediate, `rdy_` after 2 wait cycles, `rd_data`=0xDEADBEEF:
  - `bus_addr`=0x40, `rw`=1;
  - `busy` high for 4 cycles;
  - `mem_out`=0xDEADBEEF with `mem_gpr_we_`=0.
- **STW to 0x204 with data 0x12345678:**
  - `bus_rw`=0, `bus_addr`=0x81, `bus_wr_data`=0x12345678;
  - `mem_out`=0x204.
- **LDW to 0x102:**
  - no `bus_req_`, `busy`=0;
  - next cycle `mem_exp_code`=4, `mem_out`=0, `mem_gpr_we_`=1.
- **`stall` held 3 cycles after `rdy_`:**
  - FSM sits in WAIT, exactly one bus transaction occurs;
  - latch holds, then captures the read data once `stall` drops.
- **`flush` with a valid ADD result 0x55:** `mem_en_`=1, `mem_gpr_we_`=1, `mem_out`=0.
- **`reset` asserted in ACCESS:** `bus_req_`=1 and `bus_as_`=1 immediately (asynchronously); after release, state is IDLE and `busy`=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, encodings and MEM/WB payload type for the memory-access stage.
package mem_stage_pkg;

    localparam int unsigned WORD_ADDR_W = 30;
    localparam int unsigned WORD_DATA_W = 32;
    localparam int unsigned MEM_OP_W    = 2;
    localparam int unsigned CTRL_OP_W   = 2;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned ISA_EXP_W   = 3;

    // Active-low enable levels used by en_, gpr_we_ and the bus handshake
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Bus transfer direction
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam logic [MEM_OP_W-1:0]  MEM_OP_NOP = MEM_OP_W'(0);
    localparam logic [MEM_OP_W-1:0]  MEM_OP_LDW = MEM_OP_W'(1);
    localparam logic [MEM_OP_W-1:0]  MEM_OP_STW = MEM_OP_W'(2);

    localparam logic [CTRL_OP_W-1:0] CTRL_OP_NOP = CTRL_OP_W'(0);

    localparam logic [ISA_EXP_W-1:0] ISA_EXP_NO_EXP     = ISA_EXP_W'(0);
    localparam logic [ISA_EXP_W-1:0] ISA_EXP_MISS_ALIGN = ISA_EXP_W'(4);

    typedef enum logic [1:0] {
        BUS_IDLE   = 2'd0,
        BUS_REQ    = 2'd1,
        BUS_ACCESS = 2'd2,
        BUS_WAIT   = 2'd3
    } bus_state_e;

    // MEM/WB latch payload
    typedef struct packed {
        logic [WORD_ADDR_W-1:0] pc;
        logic                   en_;
        logic                   br_flag;
        logic [CTRL_OP_W-1:0]   ctrl_op;
        logic [REG_ADDR_W-1:0]  dst_addr;
        logic                   gpr_we_;
        logic [ISA_EXP_W-1:0]   exp_code;
        logic [WORD_DATA_W-1:0] out;
    } mem_wb_t;

    // Empty slot: used both as reset value and as the flush bubble
    localparam mem_wb_t MEM_WB_BUBBLE = '{
        pc:       '0,
        en_:      DISABLE_,
        br_flag:  1'b0,
        ctrl_op:  CTRL_OP_NOP,
        dst_addr: '0,
        gpr_we_:  DISABLE_,
        exp_code: ISA_EXP_NO_EXP,
        out:      '0
    };

endpackage

// File: rtl/mem_reg.sv
// MEM/WB pipeline latch: reset > stall > flush > misaligned > normal.
module mem_reg
    import mem_stage_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    stall,
    input  logic    flush,
    input  logic    miss_align,
    input  mem_wb_t ex_wb,
    output mem_wb_t mem_wb
);

    mem_wb_t miss_wb_c;

    // Misaligned access keeps its identity but retires as an exception with no writeback
    always_comb begin
        miss_wb_c          = MEM_WB_BUBBLE;
        miss_wb_c.pc       = ex_wb.pc;
        miss_wb_c.en_      = ex_wb.en_;
        miss_wb_c.br_flag  = ex_wb.br_flag;
        miss_wb_c.exp_code = ISA_EXP_MISS_ALIGN;
    end

    // Latch update with stall holding every field
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_wb <= MEM_WB_BUBBLE;
        end else if (!stall) begin
            if (flush) begin
                mem_wb <= MEM_WB_BUBBLE;
            end else if (miss_align) begin
                mem_wb <= miss_wb_c;
            end else begin
                mem_wb <= ex_wb;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: bus initiator FSM, alignment check, result mux and MEM/WB latch.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [WORD_ADDR_W-1:0] ex_pc,
    input  logic                   ex_en_,
    input  logic                   ex_br_flag,
    input  logic [MEM_OP_W-1:0]    ex_mem_op,
    input  logic [WORD_DATA_W-1:0] ex_mem_wr_data,
    input  logic [CTRL_OP_W-1:0]   ex_ctrl_op,
    input  logic [REG_ADDR_W-1:0]  ex_dst_addr,
    input  logic                   ex_gpr_we_,
    input  logic [ISA_EXP_W-1:0]   ex_exp_code,
    input  logic [WORD_DATA_W-1:0] ex_out,
    input  logic [WORD_DATA_W-1:0] bus_rd_data,
    input  logic                   bus_rdy_,
    input  logic                   bus_grnt_,
    output logic                   bus_req_,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_DATA_W-1:0] bus_wr_data,
    output logic                   busy,
    output logic [WORD_DATA_W-1:0] mem_fwd_data,
    output logic [WORD_ADDR_W-1:0] mem_pc,
    output logic                   mem_en_,
    output logic                   mem_br_flag,
    output logic [CTRL_OP_W-1:0]   mem_ctrl_op,
    output logic [REG_ADDR_W-1:0]  mem_dst_addr,
    output logic                   mem_gpr_we_,
    output logic [ISA_EXP_W-1:0]   mem_exp_code,
    output logic [WORD_DATA_W-1:0] mem_out
);

    bus_state_e             state;
    logic [WORD_DATA_W-1:0] rd_buf;

    logic                   mem_op_valid_c;
    logic                   aligned_c;
    logic                   miss_align_c;
    logic                   access_req_c;
    logic                   is_load_c;
    logic [WORD_DATA_W-1:0] result_c;
    mem_wb_t                ex_wb;
    mem_wb_t                mem_wb;

    // Decode: an incoming exception suppresses both the access and the alignment fault
    always_comb begin
        mem_op_valid_c = (ex_en_ == ENABLE_) && (ex_mem_op != MEM_OP_NOP) &&
                         (ex_exp_code == ISA_EXP_NO_EXP);
        aligned_c      = (ex_out[1:0] == 2'b00);
        miss_align_c   = mem_op_valid_c && !aligned_c;
        access_req_c   = mem_op_valid_c && aligned_c && !flush;
        is_load_c      = (ex_mem_op == MEM_OP_LDW);
    end

    // Stall request: raised from the first cycle an access is presented until rdy_
    always_comb begin
        busy = 1'b0;
        case (state)
            BUS_IDLE:   busy = access_req_c;
            BUS_REQ:    busy = 1'b1;
            BUS_ACCESS: busy = (bus_rdy_ == DISABLE_);
            BUS_WAIT:   busy = 1'b0;
            default:    busy = 1'b0;
        endcase
    end

    // Stage result: live read data while the slave answers, latched copy while stalled in WAIT
    always_comb begin
        result_c = ex_out;
        if (miss_align_c) begin
            result_c = '0;
        end else if (mem_op_valid_c && is_load_c) begin
            result_c = (state == BUS_WAIT) ? rd_buf : bus_rd_data;
        end
    end

    assign mem_fwd_data = result_c;

    // Bus initiator FSM with registered handshake and address/data outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BUS_IDLE;
            bus_req_    <= DISABLE_;
            bus_as_     <= DISABLE_;
            bus_rw      <= READ;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            rd_buf      <= '0;
        end else begin
            bus_as_ <= DISABLE_;
            case (state)
                BUS_IDLE: begin
                    if (access_req_c) begin
                        bus_req_ <= ENABLE_;
                        state    <= BUS_REQ;
                    end
                end
                BUS_REQ: begin
                    if (bus_grnt_ == ENABLE_) begin
                        bus_as_     <= ENABLE_;
                        bus_addr    <= ex_out[WORD_DATA_W-1:2];
                        bus_rw      <= is_load_c ? READ : WRITE;
                        bus_wr_data <= ex_mem_wr_data;
                        state       <= BUS_ACCESS;
                    end
                end
                BUS_ACCESS: begin
                    if (bus_rdy_ == ENABLE_) begin
                        bus_req_ <= DISABLE_;
                        rd_buf   <= bus_rd_data;
                        state    <= stall ? BUS_WAIT : BUS_IDLE;
                    end
                end
                BUS_WAIT: begin
                    if (!stall) begin
                        state <= BUS_IDLE;
                    end
                end
                default: state <= BUS_IDLE;
            endcase
        end
    end

    // Gather EX/MEM fields plus the stage result for the latch
    assign ex_wb = '{
        pc:       ex_pc,
        en_:      ex_en_,
        br_flag:  ex_br_flag,
        ctrl_op:  ex_ctrl_op,
        dst_addr: ex_dst_addr,
        gpr_we_:  ex_gpr_we_,
        exp_code: ex_exp_code,
        out:      result_c
    };

    mem_reg u_mem_reg (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .miss_align (miss_align_c),
        .ex_wb      (ex_wb),
        .mem_wb     (mem_wb)
    );

    // Unpack the latch onto the MEM/WB ports
    assign mem_pc       = mem_wb.pc;
    assign mem_en_      = mem_wb.en_;
    assign mem_br_flag  = mem_wb.br_flag;
    assign mem_ctrl_op  = mem_wb.ctrl_op;
    assign mem_dst_addr = mem_wb.dst_addr;
    assign mem_gpr_we_  = mem_wb.gpr_we_;
    assign mem_exp_code = mem_wb.exp_code;
    assign mem_out      = mem_wb.out;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; the controller is modelled as stall = busy | ext_stall.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        ext_stall;
    logic        flush;
    logic [29:0] ex_pc;
    logic        ex_en_;
    logic        ex_br_flag;
    logic [1:0]  ex_mem_op;
    logic [31:0] ex_mem_wr_data;
    logic [1:0]  ex_ctrl_op;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic [31:0] ex_out;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;
    logic        bus_grnt_;
    logic        bus_req_;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic        busy;
    logic [31:0] mem_fwd_data;
    logic [29:0] mem_pc;
    logic        mem_en_;
    logic        mem_br_flag;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic        mem_gpr_we_;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;

    int checks = 0;
    int errors = 0;

    assign stall = busy | ext_stall;

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .ex_pc          (ex_pc),
        .ex_en_         (ex_en_),
        .ex_br_flag     (ex_br_flag),
        .ex_mem_op      (ex_mem_op),
        .ex_mem_wr_data (ex_mem_wr_data),
        .ex_ctrl_op     (ex_ctrl_op),
        .ex_dst_addr    (ex_dst_addr),
        .ex_gpr_we_     (ex_gpr_we_),
        .ex_exp_code    (ex_exp_code),
        .ex_out         (ex_out),
        .bus_rd_data    (bus_rd_data),
        .bus_rdy_       (bus_rdy_),
        .bus_grnt_      (bus_grnt_),
        .bus_req_       (bus_req_),
        .bus_addr       (bus_addr),
        .bus_as_        (bus_as_),
        .bus_rw         (bus_rw),
        .bus_wr_data    (bus_wr_data),
        .busy           (busy),
        .mem_fwd_data   (mem_fwd_data),
        .mem_pc         (mem_pc),
        .mem_en_        (mem_en_),
        .mem_br_flag    (mem_br_flag),
        .mem_ctrl_op    (mem_ctrl_op),
        .mem_dst_addr   (mem_dst_addr),
        .mem_gpr_we_    (mem_gpr_we_),
        .mem_exp_code   (mem_exp_code),
        .mem_out        (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_nop();
        ex_pc          = '0;
        ex_en_         = 1'b1;
        ex_br_flag     = 1'b0;
        ex_mem_op      = 2'd0;
        ex_mem_wr_data = '0;
        ex_ctrl_op     = 2'd0;
        ex_dst_addr    = '0;
        ex_gpr_we_     = 1'b1;
        ex_exp_code    = '0;
        ex_out         = '0;
        bus_rdy_       = 1'b1;
        bus_rd_data    = '0;
        ext_stall      = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic drive_insn(input logic [1:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic gpr_we_);
        ex_pc          = 30'h10;
        ex_en_         = 1'b0;
        ex_br_flag     = 1'b0;
        ex_mem_op      = op;
        ex_mem_wr_data = wdata;
        ex_ctrl_op     = 2'd0;
        ex_dst_addr    = 5'd3;
        ex_gpr_we_     = gpr_we_;
        ex_exp_code    = '0;
        ex_out         = addr;
    endtask

    // Runs one bus access with a simple slave; called and returns at posedge+1
    task automatic do_mem(input logic [1:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int waits, input int stall_cycles,
                          output int busy_cnt, output int as_cnt,
                          output logic [29:0] a_seen, output logic rw_seen,
                          output logic [31:0] wd_seen, output logic [31:0] fwd_wait,
                          output logic [31:0] out_wait, output logic ok);
        logic in_acc;
        logic rdy_done;
        logic fin;
        int   wc;
        int   sc;
        drive_insn(op, addr, wdata, (op == 2'd1) ? 1'b0 : 1'b1);
        bus_grnt_ = 1'b0;
        busy_cnt = 0; as_cnt = 0; a_seen = '0; rw_seen = 1'b0; wd_seen = '0;
        fwd_wait = '0; out_wait = '0; ok = 1'b0;
        in_acc = 1'b0; rdy_done = 1'b0; fin = 1'b0; wc = 0; sc = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            if (!bus_as_) begin
                as_cnt++;
                a_seen = bus_addr; rw_seen = bus_rw; wd_seen = bus_wr_data;
                in_acc = 1'b1; wc = 0;
            end
            bus_rdy_ = 1'b1;
            ext_stall = 1'b0;
            if (in_acc && !rdy_done) begin
                if (wc == waits) begin
                    bus_rdy_ = 1'b0; bus_rd_data = rdata; rdy_done = 1'b1;
                    ext_stall = (stall_cycles > 0); sc = 1;
                end else begin
                    wc++;
                end
            end else if (rdy_done) begin
                ext_stall = (sc < stall_cycles); sc++;
            end
            @(negedge clk);
            if (busy) busy_cnt++;
            if (rdy_done && sc >= 2) begin
                fwd_wait = mem_fwd_data;
                out_wait = mem_out;
            end
            if (rdy_done && !stall) fin = 1'b1;
            @(posedge clk); #1;
        end
        ok = fin;
        drive_nop();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_nop();
        bus_grnt_ = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_req_ !== 1'b1)     begin errors++; $display("FAIL reset_req_ got %b exp 1", bus_req_); end
        checks++; if (bus_as_ !== 1'b1)      begin errors++; $display("FAIL reset_as_ got %b exp 1", bus_as_); end
        checks++; if (bus_rw !== 1'b1)       begin errors++; $display("FAIL reset_rw got %b exp 1", bus_rw); end
        checks++; if (bus_addr !== 30'h0)    begin errors++; $display("FAIL reset_addr got %h exp 0", bus_addr); end
        checks++; if (bus_wr_data !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", bus_wr_data); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (mem_en_ !== 1'b1)      begin errors++; $display("FAIL reset_mem_en_ got %b exp 1", mem_en_); end
        checks++; if (mem_gpr_we_ !== 1'b1)  begin errors++; $display("FAIL reset_mem_gpr_we_ got %b exp 1", mem_gpr_we_); end
        checks++; if (mem_out !== 32'h0)     begin errors++; $display("FAIL reset_mem_out got %h exp 0", mem_out); end
        checks++; if (mem_exp_code !== 3'h0) begin errors++; $display("FAIL reset_mem_exp got %h exp 0", mem_exp_code); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        int bc, ac; logic [29:0] a; logic rw; logic [31:0] wd, fw, ow; logic ok;
        do_mem(2'd1, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0, bc, ac, a, rw, wd, fw, ow, ok);
        @(negedge clk);
        checks++; if (ok !== 1'b1)            begin errors++; $display("FAIL ldw_done timeout got %b exp 1", ok); end
        checks++; if (a !== 30'h40)           begin errors++; $display("FAIL ldw_addr got %h exp 40", a); end
        checks++; if (rw !== 1'b1)            begin errors++; $display("FAIL ldw_rw got %b exp 1", rw); end
        checks++; if (bc !== 4)               begin errors++; $display("FAIL ldw_busy_cycles got %0d exp 4", bc); end
        checks++; if (ac !== 1)               begin errors++; $display("FAIL ldw_as_pulses got %0d exp 1", ac); end
        checks++; if (mem_out !== 32'hDEADBEEF) begin errors++; $display("FAIL ldw_mem_out got %h exp deadbeef", mem_out); end
        checks++; if (mem_gpr_we_ !== 1'b0)   begin errors++; $display("FAIL ldw_gpr_we_ got %b exp 0", mem_gpr_we_); end
        checks++; if (mem_dst_addr !== 5'd3)  begin errors++; $display("FAIL ldw_dst got %0d exp 3", mem_dst_addr); end
        checks++; if (bus_req_ !== 1'b1)      begin errors++; $display("FAIL ldw_req_release got %b exp 1", bus_req_); end
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        int bc, ac; logic [29:0] a; logic rw; logic [31:0] wd, fw, ow; logic ok;
        do_mem(2'd2, 32'h204, 32'h12345678, 32'hFFFFFFFF, 0, 0, bc, ac, a, rw, wd, fw, ow, ok);
        @(negedge clk);
        checks++; if (ok !== 1'b1)           begin errors++; $display("FAIL stw_done timeout got %b exp 1", ok); end
        checks++; if (rw !== 1'b0)           begin errors++; $display("FAIL stw_rw got %b exp 0", rw); end
        checks++; if (a !== 30'h81)          begin errors++; $display("FAIL stw_addr got %h exp 81", a); end
        checks++; if (wd !== 32'h12345678)   begin errors++; $display("FAIL stw_wdata got %h exp 12345678", wd); end
        checks++; if (bc !== 2)              begin errors++; $display("FAIL stw_busy_cycles got %0d exp 2", bc); end
        checks++; if (mem_out !== 32'h204)   begin errors++; $display("FAIL stw_mem_out got %h exp 204", mem_out); end
        checks++; if (mem_gpr_we_ !== 1'b1)  begin errors++; $display("FAIL stw_gpr_we_ got %b exp 1", mem_gpr_we_); end
        @(posedge clk); #1;
    endtask

    task automatic test_misalign();
        drive_insn(2'd1, 32'h102, 32'h0, 1'b0);
        bus_grnt_ = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL mis_busy got %b exp 0", busy); end
        checks++; if (mem_fwd_data !== 32'h0) begin errors++; $display("FAIL mis_fwd got %h exp 0", mem_fwd_data); end
        @(posedge clk); #1;
        drive_nop();
        @(negedge clk);
        checks++; if (bus_req_ !== 1'b1)      begin errors++; $display("FAIL mis_req_ got %b exp 1", bus_req_); end
        checks++; if (mem_exp_code !== 3'h4)  begin errors++; $display("FAIL mis_exp got %h exp 4", mem_exp_code); end
        checks++; if (mem_out !== 32'h0)      begin errors++; $display("FAIL mis_out got %h exp 0", mem_out); end
        checks++; if (mem_gpr_we_ !== 1'b1)   begin errors++; $display("FAIL mis_gpr_we_ got %b exp 1", mem_gpr_we_); end
        checks++; if (mem_en_ !== 1'b0)       begin errors++; $display("FAIL mis_en_ got %b exp 0", mem_en_); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        // Plain ALU result passes with one cycle latency
        drive_insn(2'd0, 32'h55, 32'h0, 1'b0);
        @(negedge clk);
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL alu_busy got %b exp 0", busy); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (mem_out !== 32'h55)     begin errors++; $display("FAIL alu_out got %h exp 55", mem_out); end
        checks++; if (mem_gpr_we_ !== 1'b0)   begin errors++; $display("FAIL alu_gpr_we_ got %b exp 0", mem_gpr_we_); end
        // Same instruction flushed
        flush = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (mem_en_ !== 1'b1)       begin errors++; $display("FAIL flush_en_ got %b exp 1", mem_en_); end
        checks++; if (mem_gpr_we_ !== 1'b1)   begin errors++; $display("FAIL flush_gpr_we_ got %b exp 1", mem_gpr_we_); end
        checks++; if (mem_out !== 32'h0)      begin errors++; $display("FAIL flush_out got %h exp 0", mem_out); end
        // Aligned load under flush raises no request
        drive_insn(2'd1, 32'h100, 32'h0, 1'b0);
        @(negedge clk);
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL flush_ldw_busy got %b exp 0", busy); end
        @(posedge clk); #1;
        drive_nop();
        @(negedge clk);
        checks++; if (bus_req_ !== 1'b1)      begin errors++; $display("FAIL flush_ldw_req_ got %b exp 1", bus_req_); end
        @(posedge clk); #1;
    endtask

    task automatic test_exception();
        drive_insn(2'd1, 32'h100, 32'h0, 1'b0);
        ex_exp_code = 3'h3;
        @(negedge clk);
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL exc_busy got %b exp 0", busy); end
        @(posedge clk); #1;
        drive_nop();
        @(negedge clk);
        checks++; if (mem_exp_code !== 3'h3)  begin errors++; $display("FAIL exc_code got %h exp 3", mem_exp_code); end
        checks++; if (bus_req_ !== 1'b1)      begin errors++; $display("FAIL exc_req_ got %b exp 1", bus_req_); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall_wait();
        int bc, ac; logic [29:0] a; logic rw; logic [31:0] wd, fw, ow; logic ok;
        drive_insn(2'd0, 32'h77, 32'h0, 1'b0);
        @(posedge clk); #1;
        do_mem(2'd1, 32'h180, 32'h0, 32'hCAFEF00D, 1, 3, bc, ac, a, rw, wd, fw, ow, ok);
        @(negedge clk);
        checks++; if (ok !== 1'b1)            begin errors++; $display("FAIL wait_done timeout got %b exp 1", ok); end
        checks++; if (ac !== 1)               begin errors++; $display("FAIL wait_as_pulses got %0d exp 1", ac); end
        checks++; if (bc !== 3)               begin errors++; $display("FAIL wait_busy_cycles got %0d exp 3", bc); end
        checks++; if (ow !== 32'h77)          begin errors++; $display("FAIL wait_hold got %h exp 77", ow); end
        checks++; if (fw !== 32'hCAFEF00D)    begin errors++; $display("FAIL wait_fwd got %h exp cafef00d", fw); end
        checks++; if (mem_out !== 32'hCAFEF00D) begin errors++; $display("FAIL wait_mem_out got %h exp cafef00d", mem_out); end
        checks++; if (bus_req_ !== 1'b1)      begin errors++; $display("FAIL wait_req_ got %b exp 1", bus_req_); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus_as_ !== 1'b1)       begin errors++; $display("FAIL wait_no_second_as got %b exp 1", bus_as_); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int bc, ac; logic [29:0] a; logic rw; logic [31:0] wd, fw, ow; logic ok;
        logic found;
        drive_insn(2'd1, 32'h300, 32'h0, 1'b0);
        bus_grnt_ = 1'b0;
        bus_rdy_  = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (!bus_as_) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++; if (found !== 1'b1)         begin errors++; $display("FAIL rstmid_access timeout got %b exp 1", found); end
        checks++; if (bus_req_ !== 1'b0)      begin errors++; $display("FAIL rstmid_req_before got %b exp 0", bus_req_); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus_req_ !== 1'b1)      begin errors++; $display("FAIL rstmid_req_async got %b exp 1", bus_req_); end
        checks++; if (bus_as_ !== 1'b1)       begin errors++; $display("FAIL rstmid_as_async got %b exp 1", bus_as_); end
        drive_nop();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        @(posedge clk); #1;
        do_mem(2'd2, 32'h10, 32'hA5A5A5A5, 32'h0, 0, 0, bc, ac, a, rw, wd, fw, ow, ok);
        @(negedge clk);
        checks++; if (ok !== 1'b1)            begin errors++; $display("FAIL rstmid_next timeout got %b exp 1", ok); end
        checks++; if (bc !== 2)               begin errors++; $display("FAIL rstmid_next_busy got %0d exp 2", bc); end
        checks++; if (ac !== 1)               begin errors++; $display("FAIL rstmid_next_as got %0d exp 1", ac); end
        checks++; if (mem_out !== 32'h10)     begin errors++; $display("FAIL rstmid_next_out got %h exp 10", mem_out); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_misalign();
        test_flush();
        test_exception();
        test_stall_wait();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
